// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EXE/MEM register, request/ack data-memory port with bounded wait,
// and MEM/WB register feeding write-back and the execute-stage forwarding muxes.
//
// state | meaning
// IDLE  | no access outstanding; a request, if any, comes from the op held in EXE/MEM
// BUSY  | access issued but not yet acknowledged; cnt counts wait cycles toward TIMEOUT
module mem_stage #(
    parameter int N            = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [N-1:0]            ALUResult,
    input  logic [N-1:0]            ST_value,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic                    WB_EN_in,
    input  logic                    MEM_R_EN_in,
    input  logic                    MEM_W_EN_in,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [N-1:0]            mem_addr,
    output logic [N-1:0]            mem_wdata,
    input  logic [N-1:0]            mem_rdata,
    input  logic                    mem_ack,
    output logic [N-1:0]            ALU_res_MEM,
    output logic [REG_ADDR_LEN-1:0] dest_MEM,
    output logic                    WB_EN_MEM,
    output logic [N-1:0]            result_WB,
    output logic [REG_ADDR_LEN-1:0] dest_WB,
    output logic                    WB_EN_WB,
    output logic                    misalign_err,
    output logic                    bus_err
);

    localparam int         AL  = (N == 64) ? 3 : 2;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    // EXE/MEM register
    logic                    a_valid_q, a_valid_d;
    logic [N-1:0]            a_alu_q, a_alu_d;
    logic [N-1:0]            a_st_q, a_st_d;
    logic [REG_ADDR_LEN-1:0] a_dest_q, a_dest_d;
    logic                    a_wb_q, a_wb_d;
    logic                    a_r_q, a_r_d;
    logic                    a_w_q, a_w_d;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // MEM/WB register
    logic [N-1:0]            res_wb_q, res_wb_d;
    logic [REG_ADDR_LEN-1:0] dest_wb_q, dest_wb_d;
    logic                    wb_en_wb_q, wb_en_wb_d;
    logic                    mis_q, mis_d;
    logic                    bus_q, bus_d;

    logic mem_op, aligned, misalign, tmo_hit, abort;

    assign mem_op   = a_valid_q & (a_r_q | a_w_q);
    assign aligned  = (a_alu_q[AL-1:0] == '0);
    assign misalign = mem_op & ~aligned;
    assign tmo_hit  = (state_q == BUSY) && (cnt_q == TMO);
    // Ack has priority over abort when both land on the final wait cycle.
    assign abort    = tmo_hit & ~mem_ack;

    assign mem_req   = (state_q == BUSY) | (mem_op & aligned);
    assign stall     = mem_req & ~mem_ack & ~tmo_hit;
    assign mem_we    = a_w_q;
    assign mem_addr  = a_alu_q;
    assign mem_wdata = a_st_q;

    assign ALU_res_MEM  = a_alu_q;
    assign dest_MEM     = a_dest_q;
    assign WB_EN_MEM    = a_wb_q & a_valid_q;
    assign result_WB    = res_wb_q;
    assign dest_WB      = dest_wb_q;
    assign WB_EN_WB     = wb_en_wb_q;
    assign misalign_err = mis_q;
    assign bus_err      = bus_q;

    always_comb begin
        a_valid_d = a_valid_q;
        a_alu_d   = a_alu_q;
        a_st_d    = a_st_q;
        a_dest_d  = a_dest_q;
        a_wb_d    = a_wb_q;
        a_r_d     = a_r_q;
        a_w_d     = a_w_q;
        if (!stall) begin
            a_valid_d = valid_in;
            a_alu_d   = ALUResult;
            a_st_d    = ST_value;
            a_dest_d  = dest_in;
            a_wb_d    = WB_EN_in;
            a_r_d     = MEM_R_EN_in;
            a_w_d     = MEM_W_EN_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_req && !mem_ack) begin
                    state_d = BUSY;
                    cnt_d   = 8'd1;
                end
            end
            BUSY: begin
                if (mem_ack || tmo_hit) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        res_wb_d   = res_wb_q;
        dest_wb_d  = dest_wb_q;
        wb_en_wb_d = 1'b0;
        mis_d      = 1'b0;
        bus_d      = 1'b0;
        if (!stall) begin
            res_wb_d   = a_r_q ? mem_rdata : a_alu_q;
            dest_wb_d  = a_dest_q;
            wb_en_wb_d = a_wb_q & a_valid_q & ~misalign & ~abort;
            mis_d      = misalign;
            bus_d      = abort;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_alu_q    <= '0;
            a_st_q     <= '0;
            a_dest_q   <= '0;
            a_wb_q     <= 1'b0;
            a_r_q      <= 1'b0;
            a_w_q      <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            res_wb_q   <= '0;
            dest_wb_q  <= '0;
            wb_en_wb_q <= 1'b0;
            mis_q      <= 1'b0;
            bus_q      <= 1'b0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_alu_q    <= a_alu_d;
            a_st_q     <= a_st_d;
            a_dest_q   <= a_dest_d;
            a_wb_q     <= a_wb_d;
            a_r_q      <= a_r_d;
            a_w_q      <= a_w_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_wb_q   <= res_wb_d;
            dest_wb_q  <= dest_wb_d;
            wb_en_wb_q <= wb_en_wb_d;
            mis_q      <= mis_d;
            bus_q      <= bus_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-cycle instructions plus hand sequences for wait, timeout
// and reset-in-BUSY; write-back records are checked against a scoreboard queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] ST_value = '0;
    logic [4:0]  dest_in = '0;
    logic        WB_EN_in = 1'b0;
    logic        MEM_R_EN_in = 1'b0;
    logic        MEM_W_EN_in = 1'b0;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] ALU_res_MEM, result_WB;
    logic [4:0]  dest_MEM, dest_WB;
    logic        WB_EN_MEM, WB_EN_WB, misalign_err, bus_err;

    mem_stage #(.N(32), .REG_ADDR_LEN(5), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ALUResult(ALUResult), .ST_value(ST_value),
        .dest_in(dest_in), .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ALU_res_MEM(ALU_res_MEM), .dest_MEM(dest_MEM),
        .WB_EN_MEM(WB_EN_MEM), .result_WB(result_WB), .dest_WB(dest_WB), .WB_EN_WB(WB_EN_WB),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        wb;
        logic        r;
        logic        w;
        logic        ack;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [4:0]  dest;
        logic        wb;
        logic [31:0] res;
        logic        mis;
        logic        bus;
    } wb_t;

    localparam int NV = 9;
    vec_t vecs[NV];
    vec_t bubble;
    wb_t  sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wb();
        wb_t e;
        if (WB_EN_WB === 1'b1 || misalign_err === 1'b1 || bus_err === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got wb=%0b mis=%0b bus=%0b dest=%0d res=%0h want no record",
                         WB_EN_WB, misalign_err, bus_err, dest_WB, result_WB);
            end else begin
                e = sb.pop_front();
                chk("wb_en_wb", 64'(WB_EN_WB), 64'(e.wb));
                chk("misalign_err", 64'(misalign_err), 64'(e.mis));
                chk("bus_err", 64'(bus_err), 64'(e.bus));
                if (e.wb) begin
                    chk("dest_wb", 64'(dest_WB), 64'(e.dest));
                    chk("result_wb", 64'(result_WB), 64'(e.res));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_wb();
    endtask

    task automatic set_in(input vec_t v);
        valid_in    = v.valid;
        ALUResult   = v.alu;
        ST_value    = v.st;
        dest_in     = v.dest;
        WB_EN_in    = v.wb;
        MEM_R_EN_in = v.r;
        MEM_W_EN_in = v.w;
    endtask

    // Reference model of what reaches MEM/WB for a zero-wait or non-memory instruction.
    task automatic model(input vec_t v, output logic push, output wb_t e);
        logic mis;
        mis    = v.valid & (v.r | v.w) & (v.alu[1:0] != 2'b00);
        e.dest = v.dest;
        e.wb   = v.valid & v.wb & ~mis;
        e.res  = v.r ? v.rdata : v.alu;
        e.mis  = mis;
        e.bus  = 1'b0;
        push   = v.valid & (v.wb | mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t p;
        wb_t  e;
        logic push, exp_req;
        int   stalls;
        logic done;

        bubble   = '{1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[0]  = '{1'b1, 32'h10,       32'h0,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40,       32'h0,  5'd5,  1'b1, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h42,       32'h0,  5'd6,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h44,       32'h0,  5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 32'h1111};
        vecs[4]  = '{1'b1, 32'h100,      32'hAA, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'h0,  5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5};
        vecs[6]  = '{1'b1, 32'h3,        32'h9,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h2,        32'h0,  5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h7FFC,     32'h0,  5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678};

        // reset state
        #3;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_wb_en_mem", 64'(WB_EN_MEM), 64'd0);
        chk("rst_wb_en_wb", 64'(WB_EN_WB), 64'd0);
        chk("rst_result_wb", 64'(result_WB), 64'd0);
        chk("rst_alu_res_mem", 64'(ALU_res_MEM), 64'd0);
        chk("rst_errs", 64'({misalign_err, bus_err}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // table: each vector is driven in cycle i, sits in EXE/MEM in cycle i+1
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) set_in(vecs[i]);
            else set_in(bubble);
            if (i > 0) begin
                p = vecs[i-1];
                mem_ack   = p.ack;
                mem_rdata = p.rdata;
                #1;
                exp_req = p.valid & (p.r | p.w) & (p.alu[1:0] == 2'b00);
                chk("tbl_mem_req", 64'(mem_req), 64'(exp_req));
                chk("tbl_stall", 64'(stall), 64'd0);
                chk("tbl_alu_res_mem", 64'(ALU_res_MEM), 64'(p.alu));
                chk("tbl_wb_en_mem", 64'(WB_EN_MEM), 64'(p.valid & p.wb));
                chk("tbl_dest_mem", 64'(dest_MEM), 64'(p.dest));
                if (exp_req) begin
                    chk("tbl_mem_we", 64'(mem_we), 64'(p.w));
                    chk("tbl_mem_addr", 64'(mem_addr), 64'(p.alu));
                    if (p.w) chk("tbl_mem_wdata", 64'(mem_wdata), 64'(p.st));
                end
                model(p, push, e);
                if (push) sb.push_back(e);
            end else begin
                mem_ack = 1'b0;
                #1;
            end
            tick();
        end

        // store with 3 wait cycles; next instruction waits upstream
        set_in('{1'b1, 32'h8, 32'h55, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
        mem_ack = 1'b0;
        tick();
        set_in('{1'b1, 32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        stalls = 0;
        for (int w = 0; w < 4; w++) begin
            mem_ack = (w == 3);
            #1;
            chk("st_mem_req", 64'(mem_req), 64'd1);
            chk("st_mem_we", 64'(mem_we), 64'd1);
            chk("st_mem_addr", 64'(mem_addr), 64'h8);
            chk("st_mem_wdata", 64'(mem_wdata), 64'h55);
            chk("st_alu_res_mem_hold", 64'(ALU_res_MEM), 64'h8);
            chk("st_stall", 64'(stall), 64'(w < 3));
            if (stall) stalls++;
            tick();
        end
        chk("st_stall_cycles", 64'(stalls), 64'd3);
        set_in(bubble);
        mem_ack = 1'b0;
        #1;
        chk("st_next_in_a", 64'(ALU_res_MEM), 64'h77);
        chk("st_next_wb_en_mem", 64'(WB_EN_MEM), 64'd1);
        sb.push_back('{5'd7, 1'b1, 32'h77, 1'b0, 1'b0});
        tick();

        // load that never gets acked: aborted after TIMEOUT stall cycles
        set_in('{1'b1, 32'h20, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
        mem_ack = 1'b0;
        tick();
        set_in(bubble);
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            chk("to_mem_req", 64'(mem_req), 64'd1);
            if (stall) stalls++;
            else begin
                done = 1'b1;
                sb.push_back('{5'd9, 1'b0, 32'h0, 1'b0, 1'b1});
            end
            tick();
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL to_abort: got no abort within 20 cycles want abort");
        end
        chk("to_stall_cycles", 64'(stalls), 64'd4);
        #1;
        chk("to_idle_after", 64'(mem_req), 64'd0);

        // reset asserted in the second wait cycle
        set_in('{1'b1, 32'h30, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
        mem_ack = 1'b0;
        tick();
        set_in(bubble);
        tick();
        #1;
        chk("rb_busy_req", 64'(mem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("rb_mem_req", 64'(mem_req), 64'd0);
        chk("rb_stall", 64'(stall), 64'd0);
        chk("rb_wb_en_wb", 64'(WB_EN_WB), 64'd0);
        chk("rb_wb_en_mem", 64'(WB_EN_MEM), 64'd0);
        tick();
        rst = 1'b0;
        set_in('{1'b1, 32'hABC, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        tick();
        set_in(bubble);
        #1;
        chk("rb_alu_res_mem", 64'(ALU_res_MEM), 64'hABC);
        chk("rb_after_mem_req", 64'(mem_req), 64'd0);
        chk("rb_after_stall", 64'(stall), 64'd0);
        sb.push_back('{5'd4, 1'b1, 32'hABC, 1'b0, 1'b0});
        tick();
        tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly downstream of the execute stage. It holds the EXE/MEM pipeline register, performs loads and stores over a request/acknowledge data-memory port with a bounded-wait FSM, and drives the MEM/WB register. It also produces the `ALU_res_MEM` and `result_WB` forwarding values consumed by the execute stage's operand muxes. It stalls upstream while a memory access is outstanding.

## Interface
- `N`, 32: datapath and memory word width; must be 32 or 64.
- `REG_ADDR_LEN`, 5: destination register index width.
- `TIMEOUT`, 255: maximum BUSY cycles before an access is aborted; range 1..255.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: EXE result is a real instruction (0 = bubble).
- `ALUResult` in N: EXE ALU output; used as the address for loads and stores.
- `ST_value` in N: forwarded store data from EXE.
- `dest_in` in REG_ADDR_LEN: destination register index.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in` in 1 each: write-back enable, load, store. R and W are never both 1.
- `stall` out 1: upstream must hold its outputs; the EXE/MEM register does not load.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_addr` out N: byte address.
- `mem_wdata` out N: store data.
- `mem_rdata` in N: load data, valid when `mem_ack`=1.
- `mem_ack` in 1: access complete this cycle.
- `ALU_res_MEM` out N: EXE/MEM-held ALU result (forwarding).
- `dest_MEM` out REG_ADDR_LEN, `WB_EN_MEM` out 1: forwarding-unit inputs. `WB_EN_MEM` = held WB_EN & held valid.
- `result_WB` out N: MEM/WB value; load data for loads, else ALU result.
- `dest_WB` out REG_ADDR_LEN, `WB_EN_WB` out 1: write-back control.
- `misalign_err` out 1: one-cycle pulse, aligned with MEM/WB.
- `bus_err` out 1: one-cycle pulse, aligned with MEM/WB.

## Operation
- EXE/MEM register (A) loads all `*_in` fields on each edge where `stall`=0. With `stall`=1 it holds.
- Memory op in A: `A.valid & (A.R | A.W)`.
- Aligned: low log2(N/8) bits of `A.ALUResult` are zero.
- Misaligned memory op:
  - No request is issued and there is no stall.
  - MEM/WB loads with `WB_EN_WB`=0 and `misalign_err`=1.
- `mem_addr` = `A.ALUResult`, `mem_wdata` = `A.ST_value`, `mem_we` = `A.W`. These are combinational from A and stay stable while A holds.
- FSM states IDLE and BUSY, plus an 8-bit wait counter `cnt`.
  - IDLE: `mem_req` = aligned memory op in A.
    - If `mem_req` & `mem_ack`: access completes this cycle; stay IDLE.
    - If `mem_req` & ~`mem_ack`: go to BUSY, `cnt`←1.
  - BUSY: `mem_req`=1.
    - On `mem_ack`: complete and go to IDLE.
    - Else if `cnt`==TIMEOUT: abort and go to IDLE. MEM/WB loads with `WB_EN_WB`=0 and `bus_err`=1.
    - Else `cnt`←`cnt`+1.
- `stall` = `mem_req` & ~`mem_ack` & ~(BUSY & `cnt`==TIMEOUT).
- MEM/WB register, updated every edge:
  - `stall`=1: loads a bubble (`WB_EN_WB`=0, errors 0).
  - Otherwise: loads `dest`, `WB_EN` & valid (suppressed on error), and `result_WB` = A.R ? `mem_rdata` : `A.ALUResult`.
- A store completes with the normal `WB_EN` path; stores are expected to have `WB_EN`=0.

## Timing
- Reset (asynchronous, immediate):
  - A.valid=0, FSM IDLE, `cnt`=0.
  - All outputs 0: `mem_req`, `stall`, `WB_EN_MEM`, `WB_EN_WB`, `result_WB`, `ALU_res_MEM`, errors.
- Reset during BUSY: `mem_req` drops the same cycle; the access is abandoned.
- Non-memory instructions: one cycle per stage; `result_WB` appears 1 edge after A loads.
- Zero-wait memory (`mem_ack` in the request cycle): no stall.
- k wait cycles: `stall` high for k cycles; MEM/WB loads on the ack edge.
- Timeout: `stall` is high for TIMEOUT cycles, then the abort edge.
- `mem_req` is never deasserted before ack or timeout. Address, data and we do not change while `mem_req` is high.
- `mem_ack` without `mem_req`: ignored.
- A bubble in A: no request, no stall; MEM/WB gets a bubble.

## Test plan
- **ALU pass-through.** `valid_in`=1, `ALUResult`=0x10, `WB_EN`=1, dest=3.
  - Next edge: `ALU_res_MEM`=0x10, `WB_EN_MEM`=1.
  - One edge later: `result_WB`=0x10, `dest_WB`=3, `WB_EN_WB`=1; `stall` never asserted.
- **Load, zero wait.** Load to address 0x40, `mem_ack`=1 with `mem_rdata`=0xDEADBEEF in the request cycle.
  - `mem_req`=1 for 1 cycle, no stall.
  - Next edge: `result_WB`=0xDEADBEEF.
- **Store, 3 wait cycles.** Store address 0x8, `ST_value`=0x55, ack on the 4th request cycle.
  - `stall`=1 for exactly 3 cycles.
  - `mem_we`=1, `mem_addr`=0x8, `mem_wdata`=0x55 held stable.
  - Upstream instruction enters A on the edge after ack.
- **Misaligned load.** Load address 0x42.
  - `mem_req` stays 0, no stall.
  - Next edge: `misalign_err`=1, `WB_EN_WB`=0.
- **Timeout.** TIMEOUT=4, load with `mem_ack` held 0.
  - `stall` high 4 cycles.
  - Abort edge: `bus_err`=1, `WB_EN_WB`=0, FSM IDLE.
- **Reset during BUSY.** Assert `rst` in the 2nd wait cycle.
  - `mem_req`, `stall` and `WB_EN_WB` go 0 immediately.
  - After release, a new ALU instruction flows normally.
